deser_8b: RTL and testbench

DESER_8B -- requirements
Module: deser_8b

---
 rtl/deser_8b_if.sv | 23 ++
 rtl/deser_8b.sv | 84 ++++++++
 tb/tb_deser_8b.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/deser_8b_if.sv
// deser_8b bus bundle.
// Serial input, frame control and byte output handshake.
interface deser_8b_if;
    logic       start;
    logic       bit_en;
    logic       datain_s;
    logic       msb_first;
    logic       rd_ready;
    logic [7:0] regout;
    logic       out_valid;
    logic       busy;
    logic       overrun;

    modport master (
        output start, bit_en, datain_s, msb_first, rd_ready,
        input  regout, out_valid, busy, overrun
    );

    modport slave (
        input  start, bit_en, datain_s, msb_first, rd_ready,
        output regout, out_valid, busy, overrun
    );
endinterface

// File: rtl/deser_8b.sv
// deser_8b: 8-bit serial-to-parallel converter.
// Gapped bit input, selectable bit order, sticky overrun.
module deser_8b (
    input  logic       clk,
    input  logic       rst,
    deser_8b_if.slave  bus
);

    typedef enum logic {IDLE, RECV} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d, cnt_base;
    logic [7:0] shift_q, shift_d, base, shifted;
    logic       dir_q, dir_d, sh_dir;
    logic       take, done;
    logic [7:0] regout_q;
    logic       out_valid_q, overrun_q;

    // Next frame state; a start always rebuilds the frame from zero.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        base     = shift_q;
        cnt_base = cnt_q;
        sh_dir   = dir_q;
        take     = 1'b0;
        if (bus.start) begin
            state_d  = RECV;
            dir_d    = bus.msb_first;
            base     = 8'h00;
            cnt_base = 4'd0;
            sh_dir   = bus.msb_first;
            take     = bus.bit_en;
        end else begin
            take = (state_q == RECV) && bus.bit_en;
        end
        shifted = sh_dir ? {base[6:0], bus.datain_s}
                         : {bus.datain_s, base[7:1]};
        shift_d = take ? shifted : base;
        cnt_d   = take ? cnt_base + 4'd1 : cnt_base;
        done    = take && (cnt_base == 4'd7);
        if (done) begin
            state_d = IDLE;
        end
    end

    // Frame state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 8'h00;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dir_q   <= dir_d;
        end
    end

    // Output byte, valid handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            regout_q    <= 8'h00;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (done) begin
            regout_q    <= shift_d;
            out_valid_q <= 1'b1;
            if (out_valid_q && !bus.rd_ready) begin
                overrun_q <= 1'b1;
            end
        end else if (out_valid_q && bus.rd_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.regout    = regout_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == RECV);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_deser_8b.sv
// tb_deser_8b: directed scenarios plus random traffic.
// Outputs checked every cycle against a bit-queue model.
module tb_deser_8b;

    logic clk = 1'b0;
    logic rst = 1'b1;

    deser_8b_if bus ();

    deser_8b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    bit chk_on = 1'b0;

    // Literal expectation mailbox: stimulus posts, compare consumes.
    int         lit_seq  = 0;
    int         lit_done = 0;
    string      lit_name = "";
    logic [7:0] lit_r    = 8'h00;
    logic       lit_v    = 1'b0;
    logic       lit_b    = 1'b0;
    logic       lit_o    = 1'b0;

    // Model: frame as a queue of received bits.
    bit         m_in_frame = 1'b0;
    bit         m_dir      = 1'b0;
    bit         m_valid    = 1'b0;
    bit         m_ovr      = 1'b0;
    logic [7:0] m_regout   = 8'h00;
    bit         bits[$];

    function automatic logic [7:0] pack(input bit q[$], input bit msb);
        int v;
        v = 0;
        foreach (q[i]) begin
            v += int'(q[i]) * (msb ? (1 << (7 - i)) : (1 << i));
        end
        return v[7:0];
    endfunction

    // Reference model update at every rising edge.
    always @(posedge clk) begin : model
        bit         fin;
        logic [7:0] nb;
        fin = 1'b0;
        nb  = 8'h00;
        if (rst) begin
            m_in_frame = 1'b0;
            m_dir      = 1'b0;
            m_valid    = 1'b0;
            m_ovr      = 1'b0;
            m_regout   = 8'h00;
            bits.delete();
        end else begin
            if (bus.start) begin
                bits.delete();
                m_in_frame = 1'b1;
                m_dir      = bus.msb_first;
                if (bus.bit_en) bits.push_back(bus.datain_s);
            end else if (m_in_frame && bus.bit_en) begin
                bits.push_back(bus.datain_s);
            end
            if (bits.size() == 8) begin
                nb  = pack(bits, m_dir);
                fin = 1'b1;
                m_in_frame = 1'b0;
                bits.delete();
            end
            if (fin) begin
                if (m_valid && !bus.rd_ready) m_ovr = 1'b1;
                m_regout = nb;
                m_valid  = 1'b1;
            end else if (m_valid && bus.rd_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare DUT against model and posted literals.
    always @(negedge clk) begin
        #1;
        if (chk_on) begin
            vectors++;
            if ({bus.regout, bus.out_valid, bus.busy, bus.overrun} !==
                {m_regout, m_valid, m_in_frame, m_ovr}) begin
                miscompares++;
                $display("FAIL model t=%0t got r=%02h v=%b b=%b o=%b want r=%02h v=%b b=%b o=%b",
                         $time, bus.regout, bus.out_valid, bus.busy,
                         bus.overrun, m_regout, m_valid, m_in_frame, m_ovr);
            end
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            vectors++;
            if ({bus.regout, bus.out_valid, bus.busy, bus.overrun} !==
                {lit_r, lit_v, lit_b, lit_o}) begin
                miscompares++;
                $display("FAIL %s got r=%02h v=%b b=%b o=%b want r=%02h v=%b b=%b o=%b",
                         lit_name, bus.regout, bus.out_valid, bus.busy,
                         bus.overrun, lit_r, lit_v, lit_b, lit_o);
            end
        end
    end

    task automatic tick(input logic r, input logic s, input logic be,
                        input logic d, input logic m, input logic rr);
        rst           = r;
        bus.start     = s;
        bus.bit_en    = be;
        bus.datain_s  = d;
        bus.msb_first = m;
        bus.rd_ready  = rr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string nm, input logic [7:0] r,
                              input logic v, input logic b, input logic o);
        lit_name = nm;
        lit_r    = r;
        lit_v    = v;
        lit_b    = b;
        lit_o    = o;
        lit_seq++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rr_last);
        tick(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 1, b[7 - i], 1, (i == 7) ? rr_last : 1'b0);
        end
    endtask

    initial begin
        logic [7:0] pat;
        bit         st[8];
        st = '{0, 1, 0, 0, 1, 0, 0, 0};

        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        chk_on = 1'b1;
        expect_out("reset", 8'h00, 0, 0, 0);

        // MSB-first 0xA5; msb_first toggled mid-frame must not matter.
        pat = 8'hA5;
        tick(0, 1, 0, 0, 1, 0);
        expect_out("a5_busy", 8'h00, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 1, pat[7 - i], 0, 0);
            if (i == 6) expect_out("a5_bit7", 8'h00, 0, 1, 0);
        end
        expect_out("a5_done", 8'hA5, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 1);
        expect_out("a5_read", 8'hA5, 0, 0, 0);

        // Same stream, both directions.
        tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 1, st[i], 1, 0);
        expect_out("lsb_12", 8'h12, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 1, 1, st[0], 1, 0);
        for (int i = 1; i < 8; i++) tick(0, 0, 1, st[i], 0, 0);
        expect_out("msb_48", 8'h48, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 1);

        // Gapped 0xC3 then a read pulse.
        pat = 8'hC3;
        tick(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3))
                tick(0, 0, 0, 1'($urandom_range(0, 1)), 0, 0);
            tick(0, 0, 1, pat[7 - i], 0, 0);
        end
        expect_out("gap_c3", 8'hC3, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 1);
        expect_out("gap_read", 8'hC3, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1);
        expect_out("idle_read", 8'hC3, 0, 0, 0);

        // Overrun, stickiness, then completion with rd_ready.
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        expect_out("ovr_set", 8'h22, 1, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        expect_out("ovr_sticky", 8'h22, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 0);
        expect_out("ovr_rst", 8'h00, 0, 0, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        expect_out("ovr_ready", 8'h22, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 1);

        // Restart after 5 bits, then a full 0x7E.
        pat = 8'h7E;
        tick(0, 1, 0, 0, 1, 0);
        repeat (5) tick(0, 0, 1, 1, 1, 0);
        expect_out("part5", 8'h22, 0, 1, 0);
        tick(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) tick(0, 0, 1, pat[7 - i], 1, 0);
        expect_out("restart7", 8'h22, 0, 1, 0);
        tick(0, 0, 1, pat[0], 1, 0);
        expect_out("restart_7e", 8'h7E, 1, 0, 0);

        // Reset mid-frame, then bit_en without start.
        tick(0, 1, 0, 0, 1, 0);
        repeat (3) tick(0, 0, 1, 1, 1, 0);
        tick(1, 0, 1, 1, 1, 0);
        expect_out("mid_rst", 8'h00, 0, 0, 0);
        repeat (8) tick(0, 0, 1, 1, 1, 0);
        expect_out("no_start", 8'h00, 0, 0, 0);

        // Random traffic against the model.
        repeat (600) begin
            tick(1'($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0));
        end

        tick(0, 0, 0, 0, 0, 0);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
